eth_pkt_fifo: RTL and testbench

Parametrised packet-mode store-and-forward AXI-Stream FIFO between a 10G MAC RX port and a consumer (encapsulation engine or TX MAC for loopback). It replaces the vendor packet-mode FIFO and adds three things: errored-frame handling, per-port statistics, and a post-reset resynchronisation state. Only complete frames are released downstream. The MAC RX cannot be backpressured, so on overflow the block drops the whole frame rather than stalling.

---
 rtl/eth_pkg.sv | 28 ++
 rtl/eth_sdp_ram.sv | 33 +++
 rtl/eth_pkt_fifo.sv | 166 ++++++++++++++++
 tb/tb_eth_pkt_fifo.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the packet-mode Ethernet FIFO: write FSM states
// and the bit layout of one stored entry {tuser, tlast, tkeep, tdata}.
package eth_pkg;

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      RECV,
      DROP
   } wr_state_t;

   function automatic int data_lsb(input int dw);
      return 0;
   endfunction

   function automatic int keep_lsb(input int dw);
      return dw;
   endfunction

   function automatic int tlast_bit(input int dw);
      return dw + dw / 8;
   endfunction

   function automatic int tuser_bit(input int dw);
      return dw + dw / 8 + 1;
   endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register only updates when rd_en is high, so it can act as a holding stage.
module eth_sdp_ram #(
   parameter int WIDTH      = 74,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward packet FIFO between a non-stallable MAC RX stream and an
// AXI-Stream consumer; only whole committed frames become visible downstream.
module eth_pkt_fifo
   import eth_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int DEPTH_LOG2 = 9,
   parameter int DROP_BAD   = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk156,
   input  logic                  eth_rst_n,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [DEPTH_LOG2:0]   occupancy,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic [CNT_WIDTH-1:0]  bad_cnt
);

   localparam int PW        = DEPTH_LOG2 + 1;
   localparam int EW        = DATA_WIDTH + KEEP_WIDTH + 2;
   localparam int DATA_LSB  = data_lsb(DATA_WIDTH);
   localparam int KEEP_LSB  = keep_lsb(DATA_WIDTH);
   localparam int TLAST_BIT = tlast_bit(DATA_WIDTH);
   localparam int TUSER_BIT = tuser_bit(DATA_WIDTH);

   localparam logic [PW-1:0]        DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PW-1:0]        PTR_ONE = PW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   wr_state_t            state, state_nx;
   logic [PW-1:0]        wr_ptr, wr_ptr_nx;
   logic [PW-1:0]        commit_ptr, commit_ptr_nx;
   logic [PW-1:0]        rd_ptr;
   logic [CNT_WIDTH-1:0] pkt_nx, drop_nx, bad_nx;
   logic                 wr_en;
   logic                 full;
   logic                 load;
   logic [EW-1:0]        wr_entry;
   logic [EW-1:0]        rd_entry;

   assign full = (wr_ptr - rd_ptr) == DEPTH_P;

   // tuser only carries meaning on the last beat, so it is masked before storage.
   always_comb begin
      wr_entry                              = '0;
      wr_entry[DATA_LSB +: DATA_WIDTH]      = s_axis_tdata;
      wr_entry[KEEP_LSB +: KEEP_WIDTH]      = s_axis_tkeep;
      wr_entry[TLAST_BIT]                   = s_axis_tlast;
      wr_entry[TUSER_BIT]                   = s_axis_tuser & s_axis_tlast;
   end

   always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         state      <= SYNC;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         pkt_cnt    <= '0;
         drop_cnt   <= '0;
         bad_cnt    <= '0;
      end else begin
         state      <= state_nx;
         wr_ptr     <= wr_ptr_nx;
         commit_ptr <= commit_ptr_nx;
         pkt_cnt    <= pkt_nx;
         drop_cnt   <= drop_nx;
         bad_cnt    <= bad_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      wr_ptr_nx     = wr_ptr;
      commit_ptr_nx = commit_ptr;
      pkt_nx        = pkt_cnt;
      drop_nx       = drop_cnt;
      bad_nx        = bad_cnt;
      wr_en         = 1'b0;
      case (state)
         SYNC: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_nx = IDLE;
            end
         end
         IDLE, RECV: begin
            if (s_axis_tvalid) begin
               if (full) begin
                  wr_ptr_nx = commit_ptr;
                  drop_nx   = drop_cnt + CNT_ONE;
                  state_nx  = s_axis_tlast ? IDLE : DROP;
               end else begin
                  wr_en     = 1'b1;
                  wr_ptr_nx = wr_ptr + PTR_ONE;
                  state_nx  = RECV;
                  if (s_axis_tlast) begin
                     state_nx = IDLE;
                     if (s_axis_tuser && (DROP_BAD != 0)) begin
                        wr_ptr_nx = commit_ptr;
                        bad_nx    = bad_cnt + CNT_ONE;
                     end else begin
                        commit_ptr_nx = wr_ptr + PTR_ONE;
                        pkt_nx        = pkt_cnt + CNT_ONE;
                        if (s_axis_tuser) begin
                           bad_nx = bad_cnt + CNT_ONE;
                        end
                     end
                  end
               end
            end
         end
         DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = SYNC;
      endcase
   end

   // The RAM read register doubles as the FWFT output register.
   assign load = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);

   always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         rd_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
      end else if (load) begin
         rd_ptr        <= rd_ptr + PTR_ONE;
         m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   eth_sdp_ram #(
      .WIDTH      (EW),
      .ADDR_WIDTH (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk156),
      .rst_n   (eth_rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
      .wr_data (wr_entry),
      .rd_en   (load),
      .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
      .rd_data (rd_entry)
   );

   assign m_axis_tdata = rd_entry[DATA_LSB +: DATA_WIDTH];
   assign m_axis_tkeep = rd_entry[KEEP_LSB +: KEEP_WIDTH];
   assign m_axis_tlast = rd_entry[TLAST_BIT];
   assign m_axis_tuser = rd_entry[TUSER_BIT];
   assign occupancy    = commit_ptr - rd_ptr;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Randomised bench for eth_pkt_fifo: three configurations share one input stream,
// each scenario scoreboards one of them against a frame-level model.
module tb_eth_pkt_fifo;

   localparam int DW = 64;
   localparam int KW = 8;

   typedef struct packed {
      logic          user;
      logic          last;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk156 = 1'b0;
   logic          eth_rst_n;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic [KW-1:0] s_keep;
   logic          s_last;
   logic          s_user;
   logic          m_ready;

   logic          a_valid, b_valid, c_valid;
   logic [DW-1:0] a_data, b_data, c_data;
   logic [KW-1:0] a_keep, b_keep, c_keep;
   logic          a_last, b_last, c_last;
   logic          a_user, b_user, c_user;
   logic [9:0]    a_occ, b_occ;
   logic [4:0]    c_occ;
   logic [31:0]   a_pkt, a_drop, a_bad;
   logic [31:0]   b_pkt, b_drop, b_bad;
   logic [31:0]   c_pkt, c_drop, c_bad;

   always #5 clk156 = ~clk156;

   eth_pkt_fifo u_dut_a (
      .clk156(clk156), .eth_rst_n(eth_rst_n),
      .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
      .s_axis_tlast(s_last), .s_axis_tuser(s_user),
      .m_axis_tvalid(a_valid), .m_axis_tready(m_ready), .m_axis_tdata(a_data),
      .m_axis_tkeep(a_keep), .m_axis_tlast(a_last), .m_axis_tuser(a_user),
      .occupancy(a_occ), .pkt_cnt(a_pkt), .drop_cnt(a_drop), .bad_cnt(a_bad)
   );

   eth_pkt_fifo #(.DROP_BAD(0)) u_dut_b (
      .clk156(clk156), .eth_rst_n(eth_rst_n),
      .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
      .s_axis_tlast(s_last), .s_axis_tuser(s_user),
      .m_axis_tvalid(b_valid), .m_axis_tready(m_ready), .m_axis_tdata(b_data),
      .m_axis_tkeep(b_keep), .m_axis_tlast(b_last), .m_axis_tuser(b_user),
      .occupancy(b_occ), .pkt_cnt(b_pkt), .drop_cnt(b_drop), .bad_cnt(b_bad)
   );

   eth_pkt_fifo #(.DEPTH_LOG2(4)) u_dut_c (
      .clk156(clk156), .eth_rst_n(eth_rst_n),
      .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
      .s_axis_tlast(s_last), .s_axis_tuser(s_user),
      .m_axis_tvalid(c_valid), .m_axis_tready(m_ready), .m_axis_tdata(c_data),
      .m_axis_tkeep(c_keep), .m_axis_tlast(c_last), .m_axis_tuser(c_user),
      .occupancy(c_occ), .pkt_cnt(c_pkt), .drop_cnt(c_drop), .bad_cnt(c_bad)
   );

   int          sel;
   logic        o_valid;
   beat_t       o_beat;
   logic [31:0] o_occ, o_pkt, o_drop, o_bad;

   always_comb begin
      case (sel)
         1: begin
            o_valid = b_valid;
            o_beat  = {b_user, b_last, b_keep, b_data};
            o_occ   = 32'(b_occ);
            o_pkt   = b_pkt;
            o_drop  = b_drop;
            o_bad   = b_bad;
         end
         2: begin
            o_valid = c_valid;
            o_beat  = {c_user, c_last, c_keep, c_data};
            o_occ   = 32'(c_occ);
            o_pkt   = c_pkt;
            o_drop  = c_drop;
            o_bad   = c_bad;
         end
         default: begin
            o_valid = a_valid;
            o_beat  = {a_user, a_last, a_keep, a_data};
            o_occ   = 32'(a_occ);
            o_pkt   = a_pkt;
            o_drop  = a_drop;
            o_bad   = a_bad;
         end
      endcase
   end

   int    total = 0;
   int    bad_count = 0;
   beat_t exp_q[$];
   logic  synced;
   int    exp_pkt, exp_bad, exp_drop;
   logic  stall_pending;
   beat_t stall_beat;
   int    out_beats;

   // One clock: drive at the falling edge, then scoreboard what the DUT presents.
   task automatic step(input logic v, input beat_t b, input logic rdy);
      beat_t e;
      @(negedge clk156);
      s_valid = v;
      s_data  = b.data;
      s_keep  = b.keep;
      s_last  = b.last;
      s_user  = b.user;
      m_ready = rdy;
      #1;
      if (stall_pending) begin
         total++;
         if (o_valid !== 1'b1 || o_beat !== stall_beat) begin
            bad_count++;
            $display("[TB] FAIL stall_hold: got valid=%b beat=%h, need valid=1 beat=%h",
                     o_valid, o_beat, stall_beat);
         end
      end
      if (o_valid === 1'b1 && rdy) begin
         out_beats++;
         total++;
         if (exp_q.size() == 0) begin
            bad_count++;
            $display("[TB] FAIL unexpected_beat: got %h, need no beat", o_beat);
         end else begin
            e = exp_q.pop_front();
            if (o_beat !== e) begin
               bad_count++;
               $display("[TB] FAIL out_beat: got %h, need %h", o_beat, e);
            end
         end
      end
      stall_pending = (o_valid === 1'b1) && !rdy;
      stall_beat    = o_beat;
   endtask

   function automatic logic pick_rdy(input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic idle(input int mode);
      step(1'b0, '0, pick_rdy(mode));
   endtask

   // Frame-level model: unsynced frames vanish, bad frames drop or forward, overflow drops.
   task automatic send_frame(input int len, input logic user, input logic fits,
                             input logic rand_data, input int mode);
      beat_t b;
      beat_t frame[$];
      for (int i = 0; i < len; i++) begin
         b.last = (i == len - 1);
         b.data = rand_data ? {$urandom(), $urandom()} : DW'(i + 1);
         if (b.last) b.keep = rand_data ? KW'($urandom()) : 8'h0F;
         else        b.keep = 8'hFF;
         b.user = b.last ? user : 1'($urandom_range(0, 1));
         step(1'b1, b, pick_rdy(mode));
         b.user = b.last & user;
         frame.push_back(b);
      end
      if (!synced) begin
         synced = 1'b1;
      end else if (!fits) begin
         exp_drop++;
      end else if (user && sel != 1) begin
         exp_bad++;
      end else begin
         exp_pkt++;
         if (user) exp_bad++;
         foreach (frame[k]) exp_q.push_back(frame[k]);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || o_valid === 1'b1) && n < 2000) begin
         idle(1);
         n++;
      end
      total++;
      if (exp_q.size() != 0 || o_valid === 1'b1) begin
         bad_count++;
         $display("[TB] FAIL drain: got %0d beats left valid=%b, need 0 left valid=0",
                  exp_q.size(), o_valid);
      end
   endtask

   task automatic do_reset();
      eth_rst_n = 1'b0;
      s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_user = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk156);
      eth_rst_n = 1'b1;
      exp_q.delete();
      synced = 1'b0;
      exp_pkt = 0; exp_bad = 0; exp_drop = 0;
      stall_pending = 1'b0;
      out_beats = 0;
   endtask

   task automatic test_reset();
      sel = 0;
      do_reset();
      #1;
      total++;
      if (o_valid !== 1'b0 || o_beat !== '0) begin
         bad_count++;
         $display("[TB] FAIL reset_out: got valid=%b beat=%h, need 0/0", o_valid, o_beat);
      end
      total++;
      if (o_occ !== 0 || o_pkt !== 0 || o_drop !== 0 || o_bad !== 0) begin
         bad_count++;
         $display("[TB] FAIL reset_stats: got occ=%0d pkt=%0d drop=%0d bad=%0d, need all 0",
                  o_occ, o_pkt, o_drop, o_bad);
      end
   endtask

   task automatic test_sync_latency();
      sel = 0;
      do_reset();
      send_frame(3, 1'b0, 1'b1, 1'b0, 1);
      idle(1);
      total++;
      if (o_pkt !== 0 || o_valid !== 1'b0) begin
         bad_count++;
         $display("[TB] FAIL sync_discard: got pkt=%0d valid=%b, need 0/0", o_pkt, o_valid);
      end
      send_frame(8, 1'b0, 1'b1, 1'b0, 1);
      idle(1);
      total++;
      if (o_valid !== 1'b0) begin
         bad_count++;
         $display("[TB] FAIL latency_early: got valid=%b, need 0", o_valid);
      end
      idle(1);
      total++;
      if (o_valid !== 1'b1) begin
         bad_count++;
         $display("[TB] FAIL latency_rise: got valid=%b, need 1", o_valid);
      end
      drain();
      total++;
      if (o_pkt !== 32'(exp_pkt) || o_bad !== 32'(exp_bad) || o_drop !== 32'(exp_drop)) begin
         bad_count++;
         $display("[TB] FAIL sync_counts: got pkt=%0d bad=%0d drop=%0d, need %0d/%0d/%0d",
                  o_pkt, o_bad, o_drop, exp_pkt, exp_bad, exp_drop);
      end
   endtask

   task automatic test_bad_drop();
      sel = 0;
      do_reset();
      send_frame(1, 1'b0, 1'b1, 1'b0, 1);
      send_frame(4, 1'b1, 1'b1, 1'b1, 1);
      send_frame(4, 1'b0, 1'b1, 1'b1, 1);
      drain();
      total++;
      if (o_bad !== 32'(exp_bad) || o_pkt !== 32'(exp_pkt) || exp_bad != 1) begin
         bad_count++;
         $display("[TB] FAIL bad_drop_counts: got bad=%0d pkt=%0d, need %0d/%0d",
                  o_bad, o_pkt, exp_bad, exp_pkt);
      end
   endtask

   task automatic test_bad_forward();
      sel = 1;
      do_reset();
      send_frame(1, 1'b0, 1'b1, 1'b0, 1);
      send_frame(4, 1'b1, 1'b1, 1'b1, 1);
      drain();
      total++;
      if (o_bad !== 32'd1 || o_pkt !== 32'd1 || o_drop !== 32'd0) begin
         bad_count++;
         $display("[TB] FAIL bad_fwd_counts: got bad=%0d pkt=%0d drop=%0d, need 1/1/0",
                  o_bad, o_pkt, o_drop);
      end
   endtask

   task automatic test_overflow();
      sel = 2;
      do_reset();
      send_frame(1, 1'b0, 1'b1, 1'b0, 0);
      send_frame(10, 1'b0, 1'b1, 1'b0, 0);
      idle(0);
      total++;
      if (o_occ !== 32'd10) begin
         bad_count++;
         $display("[TB] FAIL ovf_occupancy: got %0d, need 10", o_occ);
      end
      send_frame(10, 1'b0, 1'b0, 1'b1, 0);
      idle(0);
      total++;
      if (o_drop !== 32'(exp_drop) || o_pkt !== 32'(exp_pkt) || exp_drop != 1) begin
         bad_count++;
         $display("[TB] FAIL ovf_counts: got drop=%0d pkt=%0d, need %0d/%0d",
                  o_drop, o_pkt, exp_drop, exp_pkt);
      end
      out_beats = 0;
      drain();
      total++;
      if (out_beats != 10) begin
         bad_count++;
         $display("[TB] FAIL ovf_out_beats: got %0d, need 10", out_beats);
      end
   endtask

   task automatic test_back_to_back();
      sel = 0;
      do_reset();
      send_frame(1, 1'b0, 1'b1, 1'b0, 1);
      for (int f = 0; f < 64; f++) begin
         send_frame(8, 1'b0, 1'b1, 1'b1, 2);
      end
      drain();
      total++;
      if (o_pkt !== 32'd64 || o_drop !== 32'd0 || o_occ !== 32'd0) begin
         bad_count++;
         $display("[TB] FAIL b2b_counts: got pkt=%0d drop=%0d occ=%0d, need 64/0/0",
                  o_pkt, o_drop, o_occ);
      end
   endtask

   task automatic test_mid_frame_reset();
      beat_t b;
      sel = 0;
      do_reset();
      send_frame(1, 1'b0, 1'b1, 1'b0, 0);
      send_frame(4, 1'b0, 1'b1, 1'b1, 0);
      idle(0);
      idle(0);
      for (int i = 0; i < 3; i++) begin
         b.data = DW'(i + 1);
         b.keep = 8'hFF;
         b.last = 1'b0;
         b.user = 1'b0;
         step(1'b1, b, 1'b0);
      end
      eth_rst_n = 1'b0;
      #1;
      total++;
      if (o_valid !== 1'b0 || o_beat !== '0 || o_occ !== 0 || o_pkt !== 0) begin
         bad_count++;
         $display("[TB] FAIL midrst_out: got valid=%b beat=%h occ=%0d pkt=%0d, need all 0",
                  o_valid, o_beat, o_occ, o_pkt);
      end
      s_valid = 1'b0;
      repeat (2) @(negedge clk156);
      eth_rst_n = 1'b1;
      exp_q.delete();
      synced = 1'b0;
      exp_pkt = 0; exp_bad = 0; exp_drop = 0;
      stall_pending = 1'b0;
      send_frame(3, 1'b0, 1'b1, 1'b0, 1);
      send_frame(5, 1'b0, 1'b1, 1'b1, 1);
      drain();
      total++;
      if (o_pkt !== 32'd1 || o_drop !== 32'd0) begin
         bad_count++;
         $display("[TB] FAIL midrst_counts: got pkt=%0d drop=%0d, need 1/0", o_pkt, o_drop);
      end
   endtask

   initial begin
      sel = 0;
      eth_rst_n = 1'b0;
      test_reset();
      test_sync_latency();
      test_bad_drop();
      test_bad_forward();
      test_overflow();
      test_back_to_back();
      test_mid_frame_reset();
      $display("test done: total=%0d bad=%0d", total, bad_count);
      $finish;
   end

endmodule
